// File: rtl/gb_fb_pkg.sv
// -----------------------------------------------------------------------------
// gb_fb_pkg
//  Shared definitions for the GameBoy LCD framebuffer ping-pong controller:
//  default LCD geometry, per-bank depth and the controller state type.
//  No ports (package).
// -----------------------------------------------------------------------------
package gb_fb_pkg;

   localparam int GB_W_DEFAULT   = 160;
   localparam int GB_H_DEFAULT   = 144;
   localparam int ADDR_W_DEFAULT = 15;
   localparam int FB_DEPTH       = GB_W_DEFAULT * GB_H_DEFAULT;

   // FILL: writing the back bank
   // HOLD: back bank holds a complete frame waiting for vertical blank
   // SKIP: the frame currently arriving is being discarded
   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      SKIP = 2'd2
   } fb_state_t;

   function automatic int fb_depth(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/gb_fb_bank_ctrl_addr_counter.sv
// -----------------------------------------------------------------------------
// fb_addr_counter
//  Pixel index counter for one framebuffer bank. Holds the index of the next
//  incoming pixel; wraps to 0 after DEPTH-1.
// Ports
//  clk      in   1       clock
//  reset_n  in   1       asynchronous active-low reset
//  inc      in   1       a pixel is consumed this cycle
//  clear    in   1       restart the frame; the pixel consumed this cycle (if
//                        any) takes index 0
//  count    out  ADDR_W  index of the next pixel
//  last     out  1       count is DEPTH-1
// -----------------------------------------------------------------------------
module fb_addr_counter
   import gb_fb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              inc,
   input  logic              clear,
   output logic [ADDR_W-1:0] count,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] count_reg;
   logic [ADDR_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc) begin
         // clear+inc: the consumed pixel sits at index 0, so the next one is 1
         if (clear)
            count_next = ADDR_W'(1);
         else if (count_reg == LAST_ADDR)
            count_next = '0;
         else
            count_next = count_reg + ADDR_W'(1);
      end else if (clear) begin
         count_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;
   assign last  = (count_reg == LAST_ADDR);

endmodule

// File: rtl/gb_fb_bank_ctrl.sv
// -----------------------------------------------------------------------------
// gb_fb_bank_ctrl
//  Ping-pong controller for the 160x144 2-bit GameBoy LCD framebuffer. LCD
//  pixels are written into the back bank; front/back swap only on a VGA
//  vertical-blank pulse so scan-out never shows a torn frame.
//  Optional statistics: define GB_FB_STATS_EN to implement frames_dropped /
//  frames_shown; otherwise both outputs are tied to 0.
// Ports
//  clk              in   1       single clock
//  reset_n          in   1       asynchronous active-low reset
//  px_valid         in   1       pixel present on px_data
//  px_data          in   2       2-bit shade
//  lcd_frame_start  in   1       PPU starts a new frame (resync pulse)
//  vga_vblank       in   1       VGA entered vertical blank (swap point)
//  wr_en            out  1       frame RAM write strobe
//  wr_bank          out  1       bank being written
//  wr_addr          out  ADDR_W  pixel index within the bank
//  wr_data          out  2       registered px_data
//  rd_bank          out  1       bank read by VGA scan-out
//  frame_pending    out  1       back bank holds an unshown complete frame
//  frames_dropped   out  8       saturating count of discarded LCD frames
//  frames_shown     out  16      wrapping count of bank swaps
// -----------------------------------------------------------------------------
module gb_fb_bank_ctrl
   import gb_fb_pkg::*;
#(
   parameter int GB_W   = GB_W_DEFAULT,
   parameter int GB_H   = GB_H_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              px_valid,
   input  logic [1:0]        px_data,
   input  logic              lcd_frame_start,
   input  logic              vga_vblank,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_data,
   output logic              rd_bank,
   output logic              frame_pending,
   output logic [7:0]        frames_dropped,
   output logic [15:0]       frames_shown
);

   localparam int DEPTH = fb_depth(GB_W, GB_H);

   fb_state_t         state_reg, state_next;
   logic              pending_reg, pending_next;
   logic              rd_bank_reg, rd_bank_next;
   logic              wr_en_reg, wr_en_next;
   logic              wr_bank_reg, wr_bank_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic [1:0]        wr_data_reg;

   logic [ADDR_W-1:0] cnt;
   logic              cnt_last;
   logic [ADDR_W-1:0] cur_addr;
   logic              last_px;
   logic              pend_swap;
   logic              fill_now;
   logic              write_px;
   logic              complete;
   logic              swap;

   fb_addr_counter #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_addr_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (px_valid),
      .clear   (lcd_frame_start),
      .count   (cnt),
      .last    (cnt_last)
   );

   // A frame-start pulse places the pixel of the same cycle at index 0.
   assign cur_addr = lcd_frame_start ? '0 : cnt;
   assign last_px  = px_valid && !lcd_frame_start && cnt_last;

   always_comb begin
      pend_swap = vga_vblank && pending_reg;
      // Cycles in which an arriving pixel belongs to a frame we keep:
      // normal filling, a resync out of SKIP, or a HOLD that is being
      // released by this very vblank (back bank becomes free).
      fill_now  = (state_reg == FILL)
               || ((state_reg == SKIP) && lcd_frame_start)
               || ((state_reg == HOLD) && pend_swap);
      write_px  = fill_now && px_valid;
      complete  = write_px && last_px;
      swap      = pend_swap || (vga_vblank && complete);

      state_next   = state_reg;
      pending_next = pending_reg;
      rd_bank_next = swap ? ~rd_bank_reg : rd_bank_reg;

      if (fill_now) begin
         state_next = FILL;
         // Resuming writes over the back bank invalidates whatever it held.
         if (state_reg != FILL)
            pending_next = 1'b0;
         if (complete && !swap) begin
            state_next   = HOLD;
            pending_next = 1'b1;
         end
      end else if (state_reg == HOLD) begin
         if (px_valid)
            state_next = SKIP;
      end else begin
         if (pend_swap)
            pending_next = 1'b0;
         if (last_px) begin
            state_next   = FILL;
            pending_next = 1'b0;
         end
      end

      wr_en_next = write_px;
      // The final pixel of a frame swapped on the same edge still targets the
      // bank it was filling (the old back bank), not the new one.
      wr_bank_next = complete ? ~rd_bank_reg : ~rd_bank_next;

      wr_addr_next = wr_addr_reg;
      if (px_valid)
         wr_addr_next = cur_addr;
      else if (lcd_frame_start)
         wr_addr_next = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= FILL;
         pending_reg <= 1'b0;
         rd_bank_reg <= 1'b0;
         wr_en_reg   <= 1'b0;
         wr_bank_reg <= 1'b1;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         rd_bank_reg <= rd_bank_next;
         wr_en_reg   <= wr_en_next;
         wr_bank_reg <= wr_bank_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= px_data;
      end
   end

   assign wr_en         = wr_en_reg;
   assign wr_bank       = wr_bank_reg;
   assign wr_addr       = wr_addr_reg;
   assign wr_data       = wr_data_reg;
   assign rd_bank       = rd_bank_reg;
   assign frame_pending = pending_reg;

`ifdef GB_FB_STATS_EN
   logic        drop_evt;
   logic [7:0]  dropped_reg;
   logic [15:0] shown_reg;

   // A frame is lost when it starts arriving while a finished frame is still
   // waiting, or when a resync abandons a partially written frame.
   assign drop_evt = ((state_reg == HOLD) && px_valid && !pend_swap)
                  || ((state_reg == FILL) && lcd_frame_start && (cnt != '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dropped_reg <= '0;
         shown_reg   <= '0;
      end else begin
         if (drop_evt && (dropped_reg != 8'hFF))
            dropped_reg <= dropped_reg + 8'd1;
         if (swap)
            shown_reg <= shown_reg + 16'd1;
      end
   end

   assign frames_dropped = dropped_reg;
   assign frames_shown   = shown_reg;
`else
   assign frames_dropped = '0;
   assign frames_shown   = '0;
`endif

endmodule
